// File: rtl/proc_defs_pkg.sv
// Shared processor definitions: opcodes, ALUOp codes and sequencer states.
package proc_defs_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned ALU_W    = 6;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LW   = 5'd0,
    OP_SW   = 5'd1,
    OP_MOV  = 5'd2,
    OP_ADD  = 5'd3,
    OP_SUB  = 5'd4,
    OP_MUL  = 5'd5,
    OP_DIV  = 5'd6,
    OP_AND  = 5'd7,
    OP_OR   = 5'd8,
    OP_SHL  = 5'd9,
    OP_SHR  = 5'd10,
    OP_CMP  = 5'd11,
    OP_NOT  = 5'd12,
    OP_JR   = 5'd13,
    OP_JPC  = 5'd14,
    OP_BRFL = 5'd15,
    OP_CALL = 5'd16,
    OP_RET  = 5'd17,
    OP_NOP  = 5'd18
  } opcode_t;

  // ALUOp encodings shared with the ALU control decoder.
  localparam logic [ALU_W-1:0] ALU_LW_1 = 6'h00;
  localparam logic [ALU_W-1:0] ALU_LW_2 = 6'h01;
  localparam logic [ALU_W-1:0] ALU_LW_3 = 6'h02;
  localparam logic [ALU_W-1:0] ALU_SW_1 = 6'h03;
  localparam logic [ALU_W-1:0] ALU_SW_2 = 6'h04;
  localparam logic [ALU_W-1:0] ALU_MOV  = 6'h05;
  localparam logic [ALU_W-1:0] ALU_ADD  = 6'h06;
  localparam logic [ALU_W-1:0] ALU_SUB  = 6'h07;
  localparam logic [ALU_W-1:0] ALU_MUL  = 6'h08;
  localparam logic [ALU_W-1:0] ALU_DIV  = 6'h09;
  localparam logic [ALU_W-1:0] ALU_AND  = 6'h0A;
  localparam logic [ALU_W-1:0] ALU_OR   = 6'h0B;
  localparam logic [ALU_W-1:0] ALU_SHL  = 6'h0C;
  localparam logic [ALU_W-1:0] ALU_SHR  = 6'h0D;
  localparam logic [ALU_W-1:0] ALU_CMP  = 6'h0E;
  localparam logic [ALU_W-1:0] ALU_NOT  = 6'h0F;
  localparam logic [ALU_W-1:0] ALU_JR   = 6'h10;
  localparam logic [ALU_W-1:0] ALU_JPC  = 6'h11;
  localparam logic [ALU_W-1:0] ALU_BRFL = 6'h12;
  localparam logic [ALU_W-1:0] ALU_CALL = 6'h13;
  localparam logic [ALU_W-1:0] ALU_RET  = 6'h14;
  localparam logic [ALU_W-1:0] ALU_NOP  = 6'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DIV_WAIT,
    ST_LW_MEM,
    ST_LW_WB,
    ST_SW_MEM,
    ST_CALL_PUSH,
    ST_RET_POP
  } state_t;

endpackage

// File: rtl/div_wait_counter.sv
// Loadable down-counter timing the extra DIV cycles; tc_c marks the last one.
module div_wait_counter #(
  parameter int unsigned DIV_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_LATENCY - 1);

  logic [CNT_W-1:0] count_q;

  // Load on DIV entry, then count down while waiting; saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign tc_c = (count_q == CNT_W'(1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: walks each opcode through its states and
// decodes ALUOp and datapath strobes from the state and latched opcode.
module instr_sequencer
  import proc_defs_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = 4,
  parameter int unsigned ALUOP_W     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [4:0]         opcode,
  input  logic               cond_true,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               addr_we,
  output logic               mem_re,
  output logic               mem_we,
  output logic               reg_we,
  output logic               flags_we,
  output logic               sp_we,
  output logic               pc_we,
  output logic               instr_done,
  output logic               illegal
);

  state_t           state_q, state_d;
  logic [4:0]       opc_q;
  logic [ALU_W-1:0] alu_code;
  logic             div_load;
  logic             div_en;
  logic             div_tc;

  assign div_en = (state_q == ST_DIV_WAIT);
  assign alu_op = ALUOP_W'(alu_code);

  div_wait_counter #(
    .DIV_LATENCY(DIV_LATENCY)
  ) u_div_wait (
    .clk  (clk),
    .rst_n(rst_n),
    .load (div_load),
    .en   (div_en),
    .tc_c (div_tc)
  );

  // State register and opcode latch; opcode captured on handshake only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (instr_valid && instr_ready) begin
        opc_q <= opcode;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    alu_code    = ALU_NOP;
    instr_ready = 1'b0;
    addr_we     = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    flags_we    = 1'b0;
    sp_we       = 1'b0;
    pc_we       = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    div_load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        case (opc_q)
          OP_MOV: begin alu_code = ALU_MOV; reg_we = 1'b1; instr_done = 1'b1; end
          OP_ADD: begin alu_code = ALU_ADD; reg_we = 1'b1; instr_done = 1'b1; end
          OP_SUB: begin alu_code = ALU_SUB; reg_we = 1'b1; instr_done = 1'b1; end
          OP_MUL: begin alu_code = ALU_MUL; reg_we = 1'b1; instr_done = 1'b1; end
          OP_AND: begin alu_code = ALU_AND; reg_we = 1'b1; instr_done = 1'b1; end
          OP_OR:  begin alu_code = ALU_OR;  reg_we = 1'b1; instr_done = 1'b1; end
          OP_SHL: begin alu_code = ALU_SHL; reg_we = 1'b1; instr_done = 1'b1; end
          OP_SHR: begin alu_code = ALU_SHR; reg_we = 1'b1; instr_done = 1'b1; end
          OP_NOT: begin alu_code = ALU_NOT; reg_we = 1'b1; instr_done = 1'b1; end
          OP_CMP: begin alu_code = ALU_CMP; flags_we = 1'b1; instr_done = 1'b1; end
          OP_DIV: begin
            alu_code = ALU_DIV;
            if (DIV_LATENCY <= 1) begin
              reg_we     = 1'b1;
              instr_done = 1'b1;
            end else begin
              div_load = 1'b1;
              state_d  = ST_DIV_WAIT;
            end
          end
          OP_LW:   begin alu_code = ALU_LW_1; addr_we = 1'b1; state_d = ST_LW_MEM; end
          OP_SW:   begin alu_code = ALU_SW_1; addr_we = 1'b1; state_d = ST_SW_MEM; end
          OP_JR:   begin alu_code = ALU_JR;   pc_we = 1'b1;      instr_done = 1'b1; end
          OP_JPC:  begin alu_code = ALU_JPC;  pc_we = cond_true; instr_done = 1'b1; end
          OP_BRFL: begin alu_code = ALU_BRFL; pc_we = cond_true; instr_done = 1'b1; end
          OP_CALL: begin alu_code = ALU_CALL; state_d = ST_CALL_PUSH; end
          OP_RET:  begin alu_code = ALU_RET;  state_d = ST_RET_POP; end
          OP_NOP:  begin instr_done = 1'b1; end
          default: begin illegal = 1'b1; instr_done = 1'b1; end
        endcase
      end

      ST_DIV_WAIT: begin
        alu_code = ALU_DIV;
        if (div_tc) begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_LW_MEM: begin
        alu_code = ALU_LW_2;
        mem_re   = 1'b1;
        if (mem_ready) state_d = ST_LW_WB;
      end

      ST_LW_WB: begin
        alu_code   = ALU_LW_3;
        reg_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_IDLE;
      end

      ST_SW_MEM: begin
        alu_code = ALU_SW_2;
        mem_we   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_CALL_PUSH: begin
        alu_code = ALU_CALL;
        mem_we   = 1'b1;
        if (mem_ready) begin
          sp_we      = 1'b1;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_RET_POP: begin
        alu_code = ALU_RET;
        mem_re   = 1'b1;
        if (mem_ready) begin
          sp_we      = 1'b1;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with hand-computed per-cycle expectations.
module tb_instr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] opcode;
  logic       cond_true;
  logic       mem_ready;
  logic [5:0] alu_op;
  logic       addr_we, mem_re, mem_we, reg_we, flags_we, sp_we, pc_we;
  logic       instr_done, illegal;

  int total = 0;
  int bad   = 0;

  // Strobe vector bits: {ready, addr_we, mem_re, mem_we, reg_we, flags_we, sp_we, pc_we, done, illegal}
  localparam logic [9:0] RDY = 10'b10_0000_0000;
  localparam logic [9:0] AW  = 10'b01_0000_0000;
  localparam logic [9:0] RE  = 10'b00_1000_0000;
  localparam logic [9:0] WE  = 10'b00_0100_0000;
  localparam logic [9:0] RW  = 10'b00_0010_0000;
  localparam logic [9:0] FW  = 10'b00_0001_0000;
  localparam logic [9:0] SP  = 10'b00_0000_1000;
  localparam logic [9:0] PW  = 10'b00_0000_0100;
  localparam logic [9:0] DN  = 10'b00_0000_0010;
  localparam logic [9:0] IL  = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b00_0000_0000;

  instr_sequencer #(
    .DIV_LATENCY(4),
    .ALUOP_W    (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode     (opcode),
    .cond_true  (cond_true),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .addr_we    (addr_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .flags_we   (flags_we),
    .sp_we      (sp_we),
    .pc_we      (pc_we),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Compare ALUOp and all strobes against the expected vector.
  task automatic expect_out(input string tag, input logic [5:0] exp_alu, input logic [9:0] exp_s);
    logic [9:0] obs_s;
    #1;
    obs_s = {instr_ready, addr_we, mem_re, mem_we, reg_we, flags_we, sp_we, pc_we, instr_done, illegal};
    total++;
    assert ({alu_op, obs_s} === {exp_alu, exp_s}) else begin
      bad++;
      $error("FAIL %s: observed alu_op=%0h strobes=%b expected alu_op=%0h strobes=%b",
             tag, alu_op, obs_s, exp_alu, exp_s);
    end
  endtask

  // Present an opcode in IDLE, take the handshake edge, then drop valid.
  task automatic issue(input logic [4:0] op, input string tag);
    instr_valid = 1'b1;
    opcode      = op;
    expect_out({tag, "_idle"}, 6'h15, RDY);
    cyc();
    instr_valid = 1'b0;
    opcode      = 5'h1f;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = 5'd0;
    cond_true   = 1'b0;
    mem_ready   = 1'b0;
    #2;
    expect_out("reset", 6'h15, RDY);
    cyc();
    cyc();
    rst_n = 1'b1;
    expect_out("post_reset", 6'h15, RDY);

    // ADD with stray mem_ready high: ignored outside memory states
    mem_ready = 1'b1;
    issue(5'd3, "add");
    expect_out("add_exec", 6'h06, RW | DN);
    mem_ready = 1'b0;
    cyc();
    expect_out("add_idle_after", 6'h15, RDY);

    // LW with three wait cycles
    issue(5'd0, "lw");
    expect_out("lw_exec", 6'h00, AW);
    cyc(); expect_out("lw_mem1", 6'h01, RE);
    cyc(); expect_out("lw_mem2", 6'h01, RE);
    cyc(); expect_out("lw_mem3", 6'h01, RE);
    cyc(); mem_ready = 1'b1; expect_out("lw_mem4", 6'h01, RE);
    cyc(); mem_ready = 1'b0; expect_out("lw_wb", 6'h02, RW | DN);
    cyc(); expect_out("lw_idle_after", 6'h15, RDY);

    // DIV over four cycles
    issue(5'd6, "div");
    expect_out("div_c1", 6'h09, NONE);
    cyc(); expect_out("div_c2", 6'h09, NONE);
    cyc(); expect_out("div_c3", 6'h09, NONE);
    cyc(); expect_out("div_c4", 6'h09, RW | DN);
    cyc(); expect_out("div_idle_after", 6'h15, RDY);

    // Conditional jumps
    cond_true = 1'b0;
    issue(5'd14, "jpc0");
    expect_out("jpc_false", 6'h11, DN);
    cyc();
    cond_true = 1'b1;
    issue(5'd14, "jpc1");
    expect_out("jpc_true", 6'h11, PW | DN);
    cyc();
    issue(5'd15, "brfl1");
    expect_out("brfl_true", 6'h12, PW | DN);
    cyc();
    cond_true = 1'b0;
    issue(5'd13, "jr");
    expect_out("jr_exec", 6'h10, PW | DN);
    cyc();

    // CALL with two wait cycles
    issue(5'd16, "call");
    expect_out("call_exec", 6'h13, NONE);
    cyc(); expect_out("call_push1", 6'h13, WE);
    cyc(); expect_out("call_push2", 6'h13, WE);
    cyc(); mem_ready = 1'b1; expect_out("call_push3", 6'h13, WE | SP | PW | DN);
    cyc(); mem_ready = 1'b0; expect_out("call_idle_after", 6'h15, RDY);

    // RET with two wait cycles
    issue(5'd17, "ret");
    expect_out("ret_exec", 6'h14, NONE);
    cyc(); expect_out("ret_pop1", 6'h14, RE);
    cyc(); expect_out("ret_pop2", 6'h14, RE);
    cyc(); mem_ready = 1'b1; expect_out("ret_pop3", 6'h14, RE | SP | PW | DN);
    cyc(); mem_ready = 1'b0; expect_out("ret_idle_after", 6'h15, RDY);

    // SW with mem_ready already high on the first memory cycle
    mem_ready = 1'b1;
    issue(5'd1, "sw_fast");
    expect_out("sw_exec", 6'h03, AW);
    cyc(); expect_out("sw_mem_fast", 6'h04, WE | DN);
    cyc(); mem_ready = 1'b0; expect_out("sw_idle_after", 6'h15, RDY);

    // CMP, NOP, illegal opcode
    issue(5'd11, "cmp");
    expect_out("cmp_exec", 6'h0E, FW | DN);
    cyc();
    issue(5'd18, "nop");
    expect_out("nop_exec", 6'h15, DN);
    cyc();
    issue(5'd25, "ill");
    expect_out("illegal_exec", 6'h15, IL | DN);
    cyc();
    expect_out("illegal_idle_after", 6'h15, RDY);

    // Reset during SW_MEM aborts the write immediately
    issue(5'd1, "sw_abort");
    expect_out("swa_exec", 6'h03, AW);
    cyc(); expect_out("swa_mem", 6'h04, WE);
    rst_n = 1'b0;
    expect_out("swa_in_reset", 6'h15, RDY);
    cyc();
    rst_n = 1'b1;
    expect_out("swa_released", 6'h15, RDY);
    cyc();
    expect_out("swa_idle_next", 6'h15, RDY);
    issue(5'd4, "sub");
    expect_out("sub_exec", 6'h07, RW | DN);
    cyc();

    // Back-to-back: valid held high, second opcode accepted only in IDLE
    instr_valid = 1'b1;
    opcode      = 5'd2;
    expect_out("b2b_idle1", 6'h15, RDY);
    cyc();
    opcode = 5'd7;
    expect_out("b2b_mov", 6'h05, RW | DN);
    cyc();
    expect_out("b2b_idle2", 6'h15, RDY);
    cyc();
    instr_valid = 1'b0;
    expect_out("b2b_and", 6'h0A, RW | DN);
    cyc();
    expect_out("b2b_idle3", 6'h15, RDY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
